// File: rtl/switch_debounce_event_x4_pkg.sv
// Shared types and helpers for the 4-switch front end and its register block.
// Optional feature macro used by this slice: SWITCH_EVENT_BOTH_EDGES_EN.
package switch_x4_pkg;

  localparam int SW_NUM = 4;

  typedef logic [SW_NUM-1:0] sw_vec_t;

  function automatic int dbnc_cnt_w(int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/switch_debounce_event_x4_if.sv
// Switch front end <-> register block signal bundle.
// The slave side is the debouncer, the master side is the register block (or bench).
interface switch_debounce_event_x4_if
  import switch_x4_pkg::*;
  ();

  sw_vec_t sw_in;
  sw_vec_t sw_mask;
  sw_vec_t sw_event_ack;
  logic    enable_irq;
  sw_vec_t sw_state;
  sw_vec_t sw_event;
  logic    irq;

  modport master (
    output sw_in,
    output sw_mask,
    output sw_event_ack,
    output enable_irq,
    input  sw_state,
    input  sw_event,
    input  irq
  );

  modport slave (
    input  sw_in,
    input  sw_mask,
    input  sw_event_ack,
    input  enable_irq,
    output sw_state,
    output sw_event,
    output irq
  );

endinterface

// File: rtl/switch_debounce_event_x4_ch.sv
// One switch channel: 2-flop synchroniser, stability counter, debounced level.
// accept_rise/accept_fall pulse on the edge where the debounced level changes.
module switch_debounce_ch
  import switch_x4_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 100000,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic aclk,
  input  logic areset,
  input  logic sw_pin,
  output logic sw_state,
  output logic accept_rise,
  output logic accept_fall
);

  localparam int                CNT_W   = dbnc_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sync1_r <= RESET_VAL;
      sync2_r <= RESET_VAL;
    end else begin
      sync1_r <= sw_pin;
      sync2_r <= sync1_r;
    end
  end

  assign accept_s = (sync2_r != state_r) && (cnt_r == CNT_MAX);

  // Stability counter; any return to the current level restarts the count.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= RESET_VAL;
    end else if (sync2_r == state_r) begin
      cnt_r   <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_r   <= {CNT_W{1'b0}};
      state_r <= sync2_r;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  assign sw_state    = state_r;
  assign accept_rise = accept_s & sync2_r;
  assign accept_fall = accept_s & ~sync2_r;

endmodule

// File: rtl/switch_debounce_event_x4.sv
// Four debounced switches with sticky change events and a level interrupt.
// Define SWITCH_EVENT_BOTH_EDGES_EN to latch events on falling transitions too.
module switch_debounce_event_x4
  import switch_x4_pkg::*;
#(
  parameter int      DEBOUNCE_CYCLES = 100000,
  parameter sw_vec_t RESET_STATE     = 4'b0000
) (
  input  logic                        aclk,
  input  logic                        areset,
  switch_debounce_event_x4_if.slave   bus
);

  sw_vec_t state_s;
  sw_vec_t rise_s;
  sw_vec_t fall_s;
  sw_vec_t qual_s;
  sw_vec_t set_s;
  sw_vec_t event_r;
  logic    irq_r;

  for (genvar i = 0; i < SW_NUM; i++) begin : g_ch
    switch_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_STATE[i])
    ) u_ch (
      .aclk        (aclk),
      .areset      (areset),
      .sw_pin      (bus.sw_in[i]),
      .sw_state    (state_s[i]),
      .accept_rise (rise_s[i]),
      .accept_fall (fall_s[i])
    );
  end

`ifdef SWITCH_EVENT_BOTH_EDGES_EN
  assign qual_s = rise_s | fall_s;
`else
  assign qual_s = rise_s;
  // Falling accepts still move sw_state but never raise an event here.
  sw_vec_t unused_fall_s;
  assign unused_fall_s = fall_s;
`endif

  assign set_s = qual_s & ~bus.sw_mask;

  // Sticky event flags: a new event beats an ack arriving on the same edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      event_r <= 4'b0000;
    end else begin
      event_r <= set_s | (event_r & ~bus.sw_event_ack);
    end
  end

  // Registered level interrupt.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= bus.enable_irq & (|event_r);
    end
  end

  assign bus.sw_state = state_s;
  assign bus.sw_event = event_r;
  assign bus.irq      = irq_r;

endmodule

// File: tb/tb_switch_debounce_event_x4.sv
// Scoreboard bench: expected {irq, sw_event, sw_state} queued with a due cycle, checked when due.
module tb_switch_debounce_event_x4;
  import switch_x4_pkg::*;

  typedef struct {
    int         due;
    string      tag;
    logic [8:0] exp;
  } sb_t;

  logic aclk;
  logic areset;
  int   cyc;
  int   total_cnt;
  int   bad_cnt;
  sb_t  sb_q[$];

  switch_debounce_event_x4_if sw_if ();

  switch_debounce_event_x4 #(
    .DEBOUNCE_CYCLES (8),
    .RESET_STATE     (4'b0000)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (sw_if)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [8:0] mk(input logic irq, input logic [3:0] ev, input logic [3:0] st);
    return {irq, ev, st};
  endfunction

  task automatic push(input int due, input string tag, input logic [8:0] exp);
    sb_t e;
    e.due = due;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Pops every expectation that is due at this edge and compares it.
  always @(posedge aclk) begin
    #1;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      check_val(e.tag, {23'd0, sw_if.irq, sw_if.sw_event, sw_if.sw_state}, {23'd0, e.exp});
    end
  end

  task automatic pulse_ack(input logic [3:0] a);
    sw_if.sw_event_ack = a;
    wait_n(1);
    sw_if.sw_event_ack = 4'b0000;
  endtask

  initial begin
    int k;
    total_cnt = 0;
    bad_cnt   = 0;
    areset             = 1'b1;
    sw_if.sw_in        = 4'b0000;
    sw_if.sw_mask      = 4'b0000;
    sw_if.sw_event_ack = 4'b0000;
    sw_if.enable_irq   = 1'b1;
    wait_n(3);
    check_val("reset", {23'd0, sw_if.irq, sw_if.sw_event, sw_if.sw_state}, 32'd0);
    areset = 1'b0;
    wait_n(2);

    // 1: clean rise on ch0, 10-edge latency, irq one edge later, then ack
    k = cyc; sw_if.sw_in = 4'b0001;
    push(k + 9,  "t1_pre", mk(1'b0, 4'b0000, 4'b0000));
    push(k + 10, "t1_acc", mk(1'b0, 4'b0001, 4'b0001));
    push(k + 11, "t1_irq", mk(1'b1, 4'b0001, 4'b0001));
    wait_n(12);
    k = cyc;
    push(k + 1, "t1_ack", mk(1'b1, 4'b0000, 4'b0001));
    push(k + 2, "t1_irq0", mk(1'b0, 4'b0000, 4'b0001));
    pulse_ack(4'b0001);
    wait_n(3);

    // 2: ch1 bounces with 7-cycle pulses, never accepted
    for (int r = 0; r < 5; r++) begin
      sw_if.sw_in = 4'b0011;
      wait_n(7);
      sw_if.sw_in = 4'b0001;
      wait_n(7);
      push(cyc + 1, "t2_bounce", mk(1'b0, 4'b0000, 4'b0001));
    end
    wait_n(12);
    push(cyc + 1, "t2_end", mk(1'b0, 4'b0000, 4'b0001));
    wait_n(2);

    // 3: ch2 event, ack clears; ack coincident with a new accept keeps the flag
    k = cyc; sw_if.sw_in = 4'b0101;
    push(k + 10, "t3_acc", mk(1'b0, 4'b0100, 4'b0101));
    push(k + 11, "t3_irq", mk(1'b1, 4'b0100, 4'b0101));
    wait_n(12);
    k = cyc;
    push(k + 1, "t3_ack", mk(1'b1, 4'b0000, 4'b0101));
    push(k + 2, "t3_irq0", mk(1'b0, 4'b0000, 4'b0101));
    pulse_ack(4'b0100);
    wait_n(2);
    k = cyc; sw_if.sw_in = 4'b0001;
    push(k + 10, "t3_fall", mk(1'b0, 4'b0000, 4'b0001));
    wait_n(12);
    k = cyc; sw_if.sw_in = 4'b0101;
    push(k + 10, "t3_setwins", mk(1'b0, 4'b0100, 4'b0101));
    push(k + 11, "t3_setwins_irq", mk(1'b1, 4'b0100, 4'b0101));
    wait_n(9);
    pulse_ack(4'b0100);
    wait_n(2);
    k = cyc;
    push(k + 2, "t3_clear", mk(1'b0, 4'b0000, 4'b0101));
    pulse_ack(4'b0100);
    wait_n(3);

    // 4: masked ch3 follows level without event; unmasked rise sets; mask keeps latched flag
    sw_if.sw_mask = 4'b1000;
    k = cyc; sw_if.sw_in = 4'b1101;
    push(k + 10, "t4_mask_rise", mk(1'b0, 4'b0000, 4'b1101));
    push(k + 11, "t4_mask_rise2", mk(1'b0, 4'b0000, 4'b1101));
    wait_n(12);
    k = cyc; sw_if.sw_in = 4'b0101;
    push(k + 10, "t4_mask_fall", mk(1'b0, 4'b0000, 4'b0101));
    wait_n(12);
    sw_if.sw_mask = 4'b0000;
    k = cyc; sw_if.sw_in = 4'b1101;
    push(k + 10, "t4_unmask", mk(1'b0, 4'b1000, 4'b1101));
    push(k + 11, "t4_unmask_irq", mk(1'b1, 4'b1000, 4'b1101));
    wait_n(12);
    sw_if.sw_mask = 4'b1000;
    push(cyc + 2, "t4_mask_keep", mk(1'b1, 4'b1000, 4'b1101));
    wait_n(3);
    k = cyc;
    push(k + 1, "t4_mask_ack", mk(1'b1, 4'b0000, 4'b1101));
    push(k + 2, "t4_mask_ack_irq", mk(1'b0, 4'b0000, 4'b1101));
    pulse_ack(4'b1000);
    wait_n(3);
    sw_if.sw_mask = 4'b0000;

    // 5: falling edge on ch0
    k = cyc; sw_if.sw_in = 4'b1100;
`ifdef SWITCH_EVENT_BOTH_EDGES_EN
    push(k + 10, "t5_fall_ev", mk(1'b0, 4'b0001, 4'b1100));
    push(k + 11, "t5_fall_irq", mk(1'b1, 4'b0001, 4'b1100));
    wait_n(12);
    k = cyc;
    push(k + 2, "t5_clear", mk(1'b0, 4'b0000, 4'b1100));
    pulse_ack(4'b0001);
    wait_n(2);
`else
    push(k + 10, "t5_fall", mk(1'b0, 4'b0000, 4'b1100));
    push(k + 11, "t5_fall_noirq", mk(1'b0, 4'b0000, 4'b1100));
    wait_n(12);
`endif

    // 6: reset mid-event and mid-count, then a full debounce after release
    k = cyc; sw_if.sw_in = 4'b1110;
    push(k + 10, "t6_ev", mk(1'b0, 4'b0010, 4'b1110));
    push(k + 11, "t6_irq", mk(1'b1, 4'b0010, 4'b1110));
    wait_n(12);
    sw_if.sw_in = 4'b1111;
    wait_n(5);
    #2 areset = 1'b1;
    #1 check_val("t6_async_rst", {23'd0, sw_if.irq, sw_if.sw_event, sw_if.sw_state}, 32'd0);
    wait_n(2);
    areset = 1'b0;
    k = cyc;
    push(k + 9,  "t6_pre", mk(1'b0, 4'b0000, 4'b0000));
    push(k + 10, "t6_acc", mk(1'b0, 4'b1111, 4'b1111));
    push(k + 11, "t6_irq2", mk(1'b1, 4'b1111, 4'b1111));
    wait_n(14);

    check_val("sb_drain", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
